// File: rtl/mem_bus_initiator_if.sv
// Core-side request/response and memory-bus signals of the initiator, grouped for port connection.
// master = the initiator's view; slave = the core plus responder on the other side.
interface mem_bus_initiator_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  logic                  cpu_req_valid;
  logic                  cpu_req_ready;
  logic [ADDR_WIDTH-1:0] cpu_req_addr;
  logic                  cpu_req_we;
  logic [DATA_WIDTH-1:0] cpu_req_wdata;
  logic                  cpu_rsp_valid;
  logic [DATA_WIDTH-1:0] cpu_rsp_rdata;
  logic                  cpu_rsp_err;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  req_valid;
  logic                  data_valid;

  modport master (
    input  cpu_req_valid, cpu_req_addr, cpu_req_we, cpu_req_wdata, rdata, data_valid,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err, addr, we, wdata, req_valid
  );

  modport slave (
    output cpu_req_valid, cpu_req_addr, cpu_req_we, cpu_req_wdata, rdata, data_valid,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata, cpu_rsp_err, addr, we, wdata, req_valid
  );
endinterface

// File: rtl/mem_bus_initiator.sv
// Single-outstanding load/store initiator for the SoC memory bus; optional bus timeout under BUS_TIMEOUT_EN.
// Latency: bus request 1 cycle after accept, response pulse 1 cycle after data_valid (min 2 cycles accept->response).
// Backpressure: cpu_req_ready only in IDLE and not in reset; the response pulse has no back-pressure.
module mem_bus_initiator #(
  parameter int MEM_DEPTH      = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = $clog2(MEM_DEPTH),
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  mem_bus_initiator_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  generate
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
    end
  endgenerate

  state_t                state;
  logic                  req_valid_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] tmo_cnt;
  logic          rsp_err_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_valid_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt     <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req_valid) begin
            addr_q      <= bus.cpu_req_addr;
            we_q        <= bus.cpu_req_we;
            wdata_q     <= bus.cpu_req_we ? bus.cpu_req_wdata : '0;
            req_valid_q <= 1'b1;
            state       <= REQ;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end
        end
        REQ: begin
`ifdef BUS_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + CW'(1);
`endif
          // A completion on the same edge as the timeout takes priority.
          if (bus.data_valid) begin
            req_valid_q <= 1'b0;
            rsp_rdata_q <= we_q ? '0 : bus.rdata;
            rsp_valid_q <= 1'b1;
            state       <= RSP;
`ifdef BUS_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            req_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state       <= RSP;
`endif
          end
        end
        RSP: begin
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_req_ready = (state == IDLE) && !reset;
  assign bus.cpu_rsp_valid = rsp_valid_q;
  assign bus.cpu_rsp_rdata = rsp_rdata_q;
  assign bus.req_valid     = req_valid_q;
  assign bus.addr          = addr_q;
  assign bus.we            = we_q;
  assign bus.wdata         = wdata_q;
`ifdef BUS_TIMEOUT_EN
  assign bus.cpu_rsp_err   = rsp_err_q;
`else
  assign bus.cpu_rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Randomized bench for mem_bus_initiator: the bench plays core and responder, and each transaction's
// expected bus view and response are derived from its (addr, we, wdata, latency, rdata) record.
module tb_mem_bus_initiator;
  localparam int DW = 32;
  localparam int AW = 3;
`ifdef BUS_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1 << 30;
`endif

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  mem_bus_initiator_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_bus_initiator #(
    .MEM_DEPTH(8), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", tag, got, exp);
  endtask

  task automatic scramble_req();
    bus.cpu_req_addr  = AW'($urandom);
    bus.cpu_req_we    = 1'($urandom);
    bus.cpu_req_wdata = $urandom;
  endtask

  // Bench is at a negedge with the DUT idle. lat = REQ cycles before data_valid; lat+1 > TMO means silent responder.
  task automatic run_txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                         input int lat, input logic [DW-1:0] rd, input bit hold);
    bit            tmo;
    int            n_req;
    logic [DW-1:0] exp_rd;
    tmo    = (lat + 1 > TMO);
    n_req  = tmo ? TMO : lat + 1;
    exp_rd = (w || tmo) ? '0 : rd;
    check("idle_ready", bus.cpu_req_ready, 1);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = a;
    bus.cpu_req_we    = w;
    bus.cpu_req_wdata = wd;
    @(negedge clk);
    for (int i = 1; i <= n_req; i++) begin
      check("req_valid", bus.req_valid, 1);
      check("req_addr", bus.addr, a);
      check("req_we", bus.we, w);
      check("req_wdata", bus.wdata, w ? wd : '0);
      check("req_ready_low", bus.cpu_req_ready, 0);
      check("req_no_rsp", bus.cpu_rsp_valid, 0);
      if (!hold) bus.cpu_req_valid = 1'b0;
      scramble_req();
      bus.data_valid = (i == lat + 1);
      bus.rdata      = (i == lat + 1) ? rd : $urandom;
      @(negedge clk);
    end
    bus.data_valid = 1'b0;
    bus.rdata      = $urandom;
    check("rsp_valid", bus.cpu_rsp_valid, 1);
    check("rsp_rdata", bus.cpu_rsp_rdata, exp_rd);
    check("rsp_err", bus.cpu_rsp_err, tmo);
    check("rsp_req_dropped", bus.req_valid, 0);
    check("rsp_ready_low", bus.cpu_req_ready, 0);
    @(negedge clk);
    check("rsp_one_cycle", bus.cpu_rsp_valid, 0);
  endtask

  task automatic idle_gap(input int g);
    for (int k = 0; k < g; k++) begin
      bus.data_valid = 1'($urandom);
      bus.rdata      = $urandom;
      @(negedge clk);
      check("gap_ready", bus.cpu_req_ready, 1);
      check("gap_req_valid", bus.req_valid, 0);
      check("gap_rsp_valid", bus.cpu_rsp_valid, 0);
    end
    bus.data_valid = 1'b0;
  endtask

  initial begin
    bit hold;
    int lat;
    int gap;
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    bus.cpu_req_valid = 1'b1;
    bus.data_valid    = 1'b0;
    bus.rdata         = '0;
    scramble_req();

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_ready", bus.cpu_req_ready, 0);
      check("rst_req_valid", bus.req_valid, 0);
    end
    check("rst_addr", bus.addr, 0);
    check("rst_we", bus.we, 0);
    check("rst_wdata", bus.wdata, 0);
    check("rst_rsp_valid", bus.cpu_rsp_valid, 0);
    check("rst_rsp_rdata", bus.cpu_rsp_rdata, 0);
    check("rst_rsp_err", bus.cpu_rsp_err, 0);
    reset = 1'b0;
    bus.cpu_req_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", bus.cpu_req_ready, 1);
    check("post_rst_req_valid", bus.req_valid, 0);

    run_txn(3'd3, 1'b0, $urandom, 2, 32'hDEADBEEF, 1'b0);
    run_txn(3'd5, 1'b1, 32'h0000_00A5, 1, $urandom, 1'b0);
    idle_gap(3);

    // Reset in the second REQ cycle abandons the request without a response.
    check("mid_idle_ready", bus.cpu_req_ready, 1);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 3'd6;
    bus.cpu_req_we    = 1'b0;
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    check("mid_req1", bus.req_valid, 1);
    @(negedge clk);
    check("mid_req2", bus.req_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_req_valid", bus.req_valid, 0);
    check("mid_rst_no_rsp", bus.cpu_rsp_valid, 0);
    check("mid_rst_ready", bus.cpu_req_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_post_no_rsp", bus.cpu_rsp_valid, 0);
    check("mid_post_req_valid", bus.req_valid, 0);
    run_txn(3'd1, 1'b0, $urandom, 0, 32'h1234_5678, 1'b0);

`ifdef BUS_TIMEOUT_EN
    run_txn(3'd2, 1'b0, $urandom, TMO + 5, $urandom, 1'b0);
    run_txn(3'd4, 1'b0, $urandom, TMO - 1, 32'hCAFE_F00D, 1'b0);
    run_txn(3'd7, 1'b1, 32'h5A5A_0001, TMO + 2, $urandom, 1'b0);
`endif

    for (int t = 0; t < 40; t++) begin
      hold = 1'($urandom);
      lat  = $urandom_range(5, 0);
      run_txn(AW'($urandom), 1'($urandom), $urandom, lat, $urandom, hold);
      if (!hold) begin
        gap = $urandom_range(3, 0);
        idle_gap(gap);
      end
    end
    bus.cpu_req_valid = 1'b0;
    idle_gap(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
